// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-level round-robin arbiter sharing one AXI4-Stream master among N slave requesters
// s_axis_*: N requester streams (tdata slice i at [i*DATA_W +: DATA_W]); m_axis_*: shared output stream
// grant_id: current/last granted port; grant_active: a packet is being forwarded; trunc_pulse: MAX_BEATS cut a packet
module axis_pkt_arbiter #(
  parameter int N = 4,
  parameter int DATA_W = 8,
  parameter int MAX_BEATS = 16,
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                axis_aclk,
  input  logic                axis_areset,
  input  logic [N-1:0]        s_axis_tvalid,
  output logic [N-1:0]        s_axis_tready,
  input  logic [N*DATA_W-1:0] s_axis_tdata,
  input  logic [N-1:0]        s_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tlast,
  output logic [GW-1:0]       grant_id,
  output logic                grant_active,
  output logic                trunc_pulse
);
  localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_BEATS - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [GW-1:0] r_grant, r_rr, w_sel;
  logic [CW-1:0] r_cnt;
  logic r_trunc, w_lim, w_hs, w_end;
  // Scan from the farthest offset down so the nearest requester after r_rr wins.
  always_comb begin
    w_sel = r_rr;
    for (int k = N; k >= 1; k--)
      if (s_axis_tvalid[GW'((int'(r_rr) + k) % N)]) w_sel = GW'((int'(r_rr) + k) % N);
  end
  always_comb begin
    w_next = r_state;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    w_lim = (MAX_BEATS != 0) && (r_cnt == LIM);
    if (r_state == IDLE) w_next = (|s_axis_tvalid) ? BUSY : IDLE;
    else begin
      m_axis_tvalid = s_axis_tvalid[r_grant];
      m_axis_tdata = s_axis_tdata[int'(r_grant)*DATA_W +: DATA_W];
      m_axis_tlast = s_axis_tlast[r_grant] | w_lim;
      s_axis_tready[r_grant] = m_axis_tready;
      w_next = (m_axis_tvalid && m_axis_tready && m_axis_tlast) ? IDLE : BUSY;
    end
  end
  assign w_hs = m_axis_tvalid & m_axis_tready;
  assign w_end = w_hs & m_axis_tlast;
  assign grant_id = r_grant;
  assign grant_active = (r_state == BUSY);
  assign trunc_pulse = r_trunc;
  always_ff @(posedge axis_aclk)
    if (axis_areset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_grant <= '0;
      r_rr <= GW'(N - 1);
      r_cnt <= '0;
      r_trunc <= 1'b0;
    end else begin
      if (r_state == IDLE && |s_axis_tvalid) r_grant <= w_sel;
      if (w_end) r_rr <= r_grant;
      // A forced end is one whose source had not flagged TLAST itself.
      r_trunc <= w_end & ~s_axis_tlast[r_grant];
      r_cnt <= w_end ? '0 : (w_hs && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed and randomized checks of axis_pkt_arbiter against a packet-level round-robin model
module tb_axis_pkt_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic m_tvalid, m_tready, m_tlast, gact, trunc;
  logic [DW-1:0] m_tdata;
  logic [1:0] gid;
  always #5 clk = ~clk;
  axis_pkt_arbiter #(.N(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .axis_aclk(clk), .axis_areset(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .grant_id(gid), .grant_active(gact), .trunc_pulse(trunc)
  );
  typedef struct {
    int port;
    logic [7:0] d;
    bit last;
    bit forced;
  } beat_t;
  beat_t expq[$];
  int gord[$];
  logic [8:0] mem [N][128];
  int head[N], tail[N];
  bit mid[N];
  int m_rr, n_checks, n_err, exp_cycles, n_trunc;
  bit busy_exp, tr_exp, first_beat;
  int tr_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int ford[6] = '{0, 1, 2, 3, 0, 1};
  int tord[4] = '{1, 0, 1, 0};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic clear_ports();
    for (int p = 0; p < N; p++) begin
      head[p] = 0;
      tail[p] = 0;
      mid[p] = 1'b0;
    end
  endtask
  task automatic add_beat(input int p, input logic [7:0] d, input bit last);
    mem[p][tail[p]] = {last, d};
    tail[p]++;
  endtask
  task automatic add_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) add_beat(p, 8'($urandom), i == len - 1);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_rr = N - 1;
    busy_exp = 1'b0;
    tr_exp = 1'b0;
  endtask
  // Packet-level model: serve the first non-empty port after the last served one, one packet
  // (or MAX_BEATS beats) at a time, one idle cycle before each packet.
  task automatic build_model();
    int h[N];
    int p, cnt;
    logic [8:0] b;
    bit forced;
    beat_t e;
    exp_cycles = 0;
    for (int i = 0; i < N; i++) h[i] = head[i];
    while (1) begin
      p = -1;
      for (int k = N; k >= 1; k--) if (h[(m_rr + k) % N] < tail[(m_rr + k) % N]) p = (m_rr + k) % N;
      if (p < 0) break;
      cnt = 0;
      exp_cycles++;
      while (1) begin
        b = mem[p][h[p]];
        h[p]++;
        cnt++;
        exp_cycles++;
        forced = !b[8] && cnt == MB;
        e.port = p;
        e.d = b[7:0];
        e.last = b[8] | forced;
        e.forced = forced;
        expq.push_back(e);
        if (b[8] || forced || h[p] == tail[p]) break;
      end
      m_rr = p;
    end
  endtask
  task automatic cycle(input int mode, input bit gaps, input int c);
    int ep;
    bit hs;
    ep = (expq.size() > 0) ? expq[0].port : 0;
    for (int p = 0; p < N; p++) begin
      s_tvalid[p] = head[p] < tail[p];
      s_tdata[p*DW +: DW] = mem[p][head[p]][7:0];
      s_tlast[p] = mem[p][head[p]][8];
      if (gaps && busy_exp && p == ep && mid[p] && $urandom_range(3) == 0) s_tvalid[p] = 1'b0;
    end
    m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(3) != 0) : (c < 7) ? (tr_pat[c] != 0) : 1'b1;
    @(negedge clk);
    if (trunc) n_trunc++;
    check("trunc_pulse", trunc, tr_exp);
    check("grant_active", gact, busy_exp);
    if (busy_exp) begin
      check("grant_id", gid, ep);
      check("s_tready", s_tready, N'(m_tready) << ep);
      check("m_tvalid", m_tvalid, s_tvalid[ep]);
      if (m_tvalid) begin
        check("m_tdata", m_tdata, expq[0].d);
        check("m_tlast", m_tlast, expq[0].last);
      end
    end else begin
      check("idle s_tready", s_tready, 0);
      check("idle m_tvalid", m_tvalid, 0);
      check("idle m_tdata", m_tdata, 0);
      check("idle m_tlast", m_tlast, 0);
    end
    hs = busy_exp && s_tvalid[ep] && m_tready;
    tr_exp = hs && expq[0].forced;
    if (!busy_exp) begin
      busy_exp = expq.size() > 0;
      first_beat = 1'b1;
    end else if (hs) begin
      if (first_beat) gord.push_back(ep);
      first_beat = expq[0].last;
      mid[ep] = !expq[0].last;
      head[ep]++;
      if (expq[0].last) busy_exp = 1'b0;
      void'(expq.pop_front());
    end
    @(posedge clk); #1;
  endtask
  task automatic run(input string name, input int mode, input bit gaps, input bit chk_cyc);
    int c = 0;
    gord.delete();
    n_trunc = 0;
    build_model();
    busy_exp = 1'b0;
    while (expq.size() > 0 && c < 3000) begin
      cycle(mode, gaps, c);
      c++;
    end
    check({name, " drained"}, expq.size(), 0);
    if (chk_cyc) check({name, " cycles"}, c, exp_cycles);
    expq.delete();
    s_tvalid = '0;
    clear_ports();
    @(negedge clk);
    check({name, " idle after"}, gact, 0);
    check({name, " trunc after"}, trunc, tr_exp);
    tr_exp = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    n_checks = 0;
    n_err = 0;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    clear_ports();
    repeat (2) @(posedge clk);
    #1;
    check("rst grant_active", gact, 0);
    check("rst grant_id", gid, 0);
    check("rst trunc", trunc, 0);
    check("rst s_tready", s_tready, 0);
    check("rst m_tvalid", m_tvalid, 0);
    rst = 1'b0;
    m_rr = N - 1;
    busy_exp = 1'b0;
    tr_exp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("quiet m_tvalid", m_tvalid, 0);
      check("quiet s_tready", s_tready, 0);
      check("quiet grant_active", gact, 0);
      check("quiet grant_id", gid, 0);
      @(posedge clk); #1;
    end
    add_beat(2, 8'h11, 1'b0);
    add_beat(2, 8'h22, 1'b0);
    add_beat(2, 8'h33, 1'b1);
    run("single", 0, 1'b0, 1'b1);
    check("single grant", gord[0], 2);
    do_reset();
    for (int p = 0; p < N; p++) add_pkt(p, 2);
    add_pkt(0, 2);
    add_pkt(1, 2);
    run("fair", 0, 1'b0, 1'b1);
    check("fair count", gord.size(), 6);
    for (int i = 0; i < 6; i++) check("fair order", gord[i], ford[i]);
    add_pkt(1, 4);
    run("backpressure", 2, 1'b0, 1'b0);
    add_pkt(0, 20);
    run("trunc", 0, 1'b0, 1'b1);
    check("trunc pulses", n_trunc, 1);
    add_pkt(0, 20);
    add_pkt(1, 2);
    add_pkt(1, 2);
    run("trunc share", 0, 1'b0, 1'b1);
    check("trunc share count", gord.size(), 4);
    for (int i = 0; i < 4; i++) check("trunc share order", gord[i], tord[i]);
    s_tvalid = 4'b1000;
    s_tdata[3*DW +: DW] = 8'hA0;
    s_tlast = '0;
    m_tready = 1'b1;
    @(negedge clk);
    check("mr arb idle", gact, 0);
    @(posedge clk); #1;
    s_tvalid = 4'b1010;
    s_tdata[1*DW +: DW] = 8'h55;
    @(negedge clk);
    check("mr beat1", m_tdata, 8'hA0);
    check("mr grant", gid, 3);
    @(posedge clk); #1;
    s_tdata[3*DW +: DW] = 8'hA1;
    @(negedge clk);
    check("mr beat2", m_tdata, 8'hA1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr grant_active", gact, 0);
    check("mr grant_id", gid, 0);
    check("mr trunc", trunc, 0);
    check("mr s_tready", s_tready, 0);
    check("mr m_tvalid", m_tvalid, 0);
    check("mr m_tdata", m_tdata, 0);
    check("mr m_tlast", m_tlast, 0);
    m_rr = N - 1;
    busy_exp = 1'b0;
    tr_exp = 1'b0;
    add_pkt(1, 2);
    add_pkt(3, 5);
    run("mr resume", 0, 1'b0, 1'b1);
    check("mr resume first", gord[0], 1);
    check("mr resume second", gord[1], 3);
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < N; p++) begin
        int np;
        np = $urandom_range(3);
        for (int j = 0; j < np; j++) add_pkt(p, $urandom_range(1, 20));
      end
      run("random", 1, 1'b1, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
